// File: rtl/mic_level_meter.sv
// Microphone peak meter: decimates mic_in, tracks the window peak, publishes a 0..16 bar level.
// Optional macro PEAK_DECAY_EN: instant attack, one-bar-per-window fall instead of no hold.
module mic_level_meter #(
    parameter int SAMPLE_DIV     = 5000,
    parameter int WINDOW_SAMPLES = 4000,
    parameter int MID_SCALE      = 2048
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] mic_in,
    output logic [4:0]  level,
    output logic [15:0] tester,
    output logic        level_valid
);

    localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WW = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_DIV - 1);
    localparam logic [WW-1:0] WIN_LAST    = WW'(WINDOW_SAMPLES - 1);
    localparam logic [11:0]   MID         = 12'(MID_SCALE);

    logic [SW-1:0] sample_cnt;
    logic [WW-1:0] win_cnt;
    logic [11:0]   peak;
    logic          strobe;
    logic          win_close;
    logic [11:0]   pk;
    logic [11:0]   amp;
    logic [4:0]    step;
    logic [4:0]    new_level;
    logic [4:0]    next_level;
    logic [15:0]   next_tester;

    assign strobe    = (sample_cnt == SAMPLE_LAST);
    assign win_close = strobe && (win_cnt == WIN_LAST);
    // Closing sample participates in the window peak.
    assign pk        = (mic_in > peak) ? mic_in : peak;

    always_comb begin
        amp         = 12'd0;
        step        = 5'd0;
        new_level   = 5'd0;
        next_level  = 5'd0;
        next_tester = 16'h0000;

        if (pk >= MID) begin
            amp = pk - MID;
        end

        step = 5'((amp - 12'd64) >> 7);
        if (amp < 12'd64) begin
            new_level = 5'd0;
        end else if (step >= 5'd16) begin
            new_level = 5'd16;
        end else begin
            new_level = step + 5'd1;
        end

`ifdef PEAK_DECAY_EN
        if (new_level >= level) begin
            next_level = new_level;
        end else begin
            next_level = level - 5'd1;
        end
`else
        next_level = new_level;
`endif

        // A shift by 16 clears the mask, giving the all-ones code for 16 bars.
        next_tester = ~(16'hFFFF << next_level);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_cnt  <= '0;
            win_cnt     <= '0;
            peak        <= 12'd0;
            level       <= 5'd0;
            tester      <= 16'h0000;
            level_valid <= 1'b0;
        end else begin
            level_valid <= win_close;

            if (strobe) begin
                sample_cnt <= '0;
            end else begin
                sample_cnt <= sample_cnt + 1'b1;
            end

            if (strobe) begin
                if (win_close) begin
                    win_cnt <= '0;
                    peak    <= 12'd0;
                    level   <= next_level;
                    tester  <= next_tester;
                end else begin
                    win_cnt <= win_cnt + 1'b1;
                    peak    <= pk;
                end
            end
        end
    end

endmodule

// File: tb/tb_mic_level_meter.sv
// Self-checking bench for mic_level_meter with a 4-clock sample strobe and 8-sample window.
module tb_mic_level_meter;

    localparam int SD = 4;
    localparam int WS = 8;
    localparam int WIN = SD * WS;

    logic        clock;
    logic        reset;
    logic [11:0] mic_in;
    logic [4:0]  level;
    logic [15:0] tester;
    logic        level_valid;

    int checks = 0;
    int failures = 0;
    bit started = 0;

    mic_level_meter #(
        .SAMPLE_DIV(SD),
        .WINDOW_SAMPLES(WS),
        .MID_SCALE(2048)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mic_in(mic_in),
        .level(level),
        .tester(tester),
        .level_valid(level_valid)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    function automatic int quant(input int pkv);
        int amp;
        int q;
        amp = (pkv >= 2048) ? pkv - 2048 : 0;
        if (amp < 64) q = 0;
        else q = (amp - 64) / 128 + 1;
        if (q > 16) q = 16;
        return q;
    endfunction

    function automatic logic [15:0] therm(input int n);
        logic [15:0] t;
        t = 16'h0000;
        for (int i = 0; i < 16; i++) if (i < n) t[i] = 1'b1;
        return t;
    endfunction

    // Reference model: collect one sample per strobe, evaluate the window when it fills.
    int          cyc;
    logic [11:0] win_q[$];
    int          m_level;
    bit          m_valid;

    initial begin
        cyc = 0;
        m_level = 0;
        m_valid = 0;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                cyc = 0;
                win_q.delete();
                m_level = 0;
                m_valid = 0;
            end else begin
                int pkv;
                int nl;
                m_valid = 0;
                cyc++;
                if (cyc % SD == 0) begin
                    win_q.push_back(mic_in);
                    if (win_q.size() == WS) begin
                        pkv = 0;
                        foreach (win_q[i]) if (int'(win_q[i]) > pkv) pkv = int'(win_q[i]);
                        nl = quant(pkv);
`ifdef PEAK_DECAY_EN
                        m_level = (nl >= m_level) ? nl : m_level - 1;
`else
                        m_level = nl;
`endif
                        m_valid = 1;
                        win_q.delete();
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (started && !reset) begin
                checks++;
                if (level !== 5'(m_level)) begin
                    failures++;
                    $display("FAIL cyc_level t=%0t: level=%0d expected %0d", $time, level, m_level);
                end
                checks++;
                if (tester !== therm(m_level)) begin
                    failures++;
                    $display("FAIL cyc_tester t=%0t: tester=%h expected %h", $time, tester, therm(m_level));
                end
                checks++;
                if (level_valid !== m_valid) begin
                    failures++;
                    $display("FAIL cyc_valid t=%0t: level_valid=%b expected %b", $time, level_valid, m_valid);
                end
            end
        end
    end

    task automatic check_lit(input string name, input int exp_lvl, input logic [15:0] exp_t);
        checks++;
        if (level_valid !== 1'b1 || level !== 5'(exp_lvl) || tester !== exp_t) begin
            failures++;
            $display("FAIL %s: valid=%b level=%0d tester=%h expected valid=1 level=%0d tester=%h",
                     name, level_valid, level, tester, exp_lvl, exp_t);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (level !== 5'd0 || tester !== 16'h0000 || level_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s: level=%0d tester=%h valid=%b expected 0 0000 0",
                     name, level, tester, level_valid);
        end
    endtask

    // Starts at the negedge before the window's first posedge; ends just after its close.
    // mode 0: clean, 1: noise between strobes, 2: random strobe samples plus noise.
    task automatic run_window(input logic [11:0] base, input logic [11:0] pk,
                              input int pk_idx, input int mode);
        int hi;
        int s;
        hi = $urandom_range(0, 4095);
        for (int k = 0; k < WIN; k++) begin
            if ((k + 1) % SD == 0) begin
                s = (k + 1) / SD - 1;
                if (mode == 2) mic_in = 12'($urandom_range(0, hi));
                else mic_in = (s == pk_idx) ? pk : base;
            end else begin
                mic_in = (mode > 0) ? 12'($urandom) : base;
            end
            @(negedge clock);
        end
    endtask

    initial begin
        int exp_l;
        int n;
        reset = 0;
        mic_in = 12'd2048;

        #3 reset = 1;
        #1 check_zero("reset_immediate");
        started = 1;
        repeat (3) @(negedge clock);
        reset = 0;

        for (int w = 0; w < 2; w++) begin
            run_window(12'd2048, 12'd2048, 0, 0);
            check_lit("steady_mid", 0, 16'h0000);
        end

        run_window(12'd2048, 12'd4095, 3, 1);
        check_lit("full_scale", 16, 16'hFFFF);

        for (int w = 1; w <= 16; w++) begin
            run_window(12'd2048, 12'd2048, 0, 1);
`ifdef PEAK_DECAY_EN
            exp_l = 16 - w;
`else
            exp_l = 0;
`endif
            check_lit("decay_seq", exp_l, therm(exp_l));
        end

        run_window(12'd2048, 12'd2111, 7, 0);
        check_lit("amp63", 0, 16'h0000);
        run_window(12'd2048, 12'd2112, 7, 0);
        check_lit("amp64", 1, 16'h0001);
        run_window(12'd2048, 12'd2624, 7, 0);
        check_lit("amp576_close", 5, 16'h001F);
        run_window(12'd0, 12'd2047, 2, 1);
`ifdef PEAK_DECAY_EN
        check_lit("below_mid", 4, 16'h000F);
`else
        check_lit("below_mid", 0, 16'h0000);
`endif

        for (int w = 0; w < 6; w++) run_window(12'd0, 12'd0, 0, 2);

        run_window(12'd2048, 12'd4095, 0, 0);
        check_lit("pre_reset_full", 16, 16'hFFFF);
        mic_in = 12'd4095;
        repeat (13) @(negedge clock);
        reset = 1;
        #1 check_zero("reset_mid_window");
        mic_in = 12'd2048;
        repeat (2) @(negedge clock);
        reset = 0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (level_valid === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != WIN) begin
            failures++;
            $display("FAIL reset_release_latency: valid after %0d cycles expected %0d", n, WIN);
        end
        check_lit("post_reset_peak_cleared", 0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
